// File: rtl/movement_commander.sv
`default_nettype none
// ============================================================================
// Module   : movement_commander
// Function : Issues debounce-friendly left/right button pulses to walk the
//            movement FSM to a requested position code, then reports done/err.
// Revision : 1.0  initial release
// ============================================================================
module movement_commander #(
  parameter int PULSE_LEN = 2,
  parameter int GAP_LEN   = 2,
  parameter int MAX_STEPS = 6
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [2:0] target,
  input  logic [2:0] pos,
  output logic       l_out,
  output logic       r_out,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [2:0] steps
);

  localparam int              c_cnt_max   = (PULSE_LEN > GAP_LEN) ? PULSE_LEN : GAP_LEN;
  localparam int              c_cnt_w     = (c_cnt_max > 1) ? $clog2(c_cnt_max) : 1;
  localparam logic [c_cnt_w-1:0] c_pulse_last = c_cnt_w'(PULSE_LEN - 1);
  localparam logic [c_cnt_w-1:0] c_gap_last   = c_cnt_w'(GAP_LEN - 1);
  localparam logic [2:0]      c_invalid   = 3'b111;
  localparam logic [2:0]      c_max_steps = 3'(MAX_STEPS);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CHECK = 3'd1,
    S_PULSE = 3'd2,
    S_GAP   = 3'd3,
    S_DONE  = 3'd4,
    S_ERR   = 3'd5
  } state_t;

  // Codes 001..011 sit on the L side (-1..-3), 100..110 on the R side (+1..+3).
  function automatic logic signed [3:0] pos_idx(input logic [2:0] code);
    case (code)
      3'b001:  pos_idx = -4'sd1;
      3'b010:  pos_idx = -4'sd2;
      3'b011:  pos_idx = -4'sd3;
      3'b100:  pos_idx = 4'sd1;
      3'b101:  pos_idx = 4'sd2;
      3'b110:  pos_idx = 4'sd3;
      default: pos_idx = 4'sd0;
    endcase
  endfunction

  state_t             r_state, w_state;
  logic [c_cnt_w-1:0] r_cnt, w_cnt;
  logic [2:0]         r_target, w_target;
  logic [2:0]         r_pos_before, w_pos_before;
  logic               r_dir_left, w_dir_left;
  logic [2:0]         r_steps, w_steps;
  logic               r_l, w_l, r_r, w_r;
  logic               r_busy, w_busy, r_done, w_done, r_err, w_err;
  logic signed [3:0]  w_pos_idx, w_tgt_idx;

  assign w_pos_idx = pos_idx(pos);
  assign w_tgt_idx = pos_idx(r_target);

  always_comb begin
    w_state      = r_state;
    w_cnt        = r_cnt;
    w_target     = r_target;
    w_pos_before = r_pos_before;
    w_dir_left   = r_dir_left;
    w_steps      = r_steps;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_steps = 3'd0;
          if (target == c_invalid) begin
            w_state = S_ERR;
          end else begin
            w_target = target;
            w_state  = S_CHECK;
          end
        end
      end
      S_CHECK: begin
        if (pos == c_invalid) begin
          w_state = S_ERR;
        end else if (w_pos_idx == w_tgt_idx) begin
          w_state = S_DONE;
        end else if (r_steps == c_max_steps) begin
          w_state = S_ERR;
        end else begin
          w_pos_before = pos;
          w_dir_left   = (w_pos_idx > w_tgt_idx);
          w_steps      = r_steps + 3'd1;
          w_cnt        = '0;
          w_state      = S_PULSE;
        end
      end
      S_PULSE: begin
        if (r_cnt == c_pulse_last) begin
          w_cnt   = '0;
          w_state = S_GAP;
        end else begin
          w_cnt = r_cnt + 1'b1;
        end
      end
      S_GAP: begin
        // Movement away from target still counts as progress; CHECK re-aims.
        if (r_cnt == c_gap_last) begin
          w_cnt   = '0;
          w_state = (pos == r_pos_before) ? S_ERR : S_CHECK;
        end else begin
          w_cnt = r_cnt + 1'b1;
        end
      end
      S_DONE:  w_state = S_IDLE;
      S_ERR:   w_state = S_IDLE;
      default: w_state = S_IDLE;
    endcase

    // Outputs are registered from the next state so they line up with it.
    w_l    = (w_state == S_PULSE) && w_dir_left;
    w_r    = (w_state == S_PULSE) && !w_dir_left;
    w_busy = (w_state == S_CHECK) || (w_state == S_PULSE) || (w_state == S_GAP);
    w_done = (w_state == S_DONE);
    w_err  = (w_state == S_ERR);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_target     <= 3'b000;
      r_pos_before <= 3'b000;
      r_dir_left   <= 1'b0;
      r_steps      <= 3'd0;
      r_l          <= 1'b0;
      r_r          <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_state      <= w_state;
      r_cnt        <= w_cnt;
      r_target     <= w_target;
      r_pos_before <= w_pos_before;
      r_dir_left   <= w_dir_left;
      r_steps      <= w_steps;
      r_l          <= w_l;
      r_r          <= w_r;
      r_busy       <= w_busy;
      r_done       <= w_done;
      r_err        <= w_err;
    end
  end

  assign l_out = r_l;
  assign r_out = r_r;
  assign busy  = r_busy;
  assign done  = r_done;
  assign err   = r_err;
  assign steps = r_steps;

endmodule
`default_nettype wire

// File: tb/tb_movement_commander.sv
`default_nettype none
// ============================================================================
// Module   : tb_movement_commander
// Function : Directed bench with a behavioural movement FSM feeding pos back.
// Revision : 1.0  initial release
// ============================================================================
module tb_movement_commander;

  logic       clk, reset, start;
  logic [2:0] target, pos;
  logic       l_out, r_out, busy, done, err;
  logic [2:0] steps;

  int errors = 0;
  int checks = 0;

  int   m_idx;
  int   set_val;
  bit   set_req;
  bit   stuck;
  logic m_prev_l, m_prev_r;

  movement_commander #(.PULSE_LEN(2), .GAP_LEN(2), .MAX_STEPS(6)) dut (
    .clk(clk), .reset(reset), .start(start), .target(target), .pos(pos),
    .l_out(l_out), .r_out(r_out), .busy(busy), .done(done), .err(err), .steps(steps)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Movement FSM stand-in: one index step per rising edge of a button line.
  always @(posedge clk) begin
    m_prev_l <= l_out;
    m_prev_r <= r_out;
    if (set_req) begin
      m_idx <= set_val;
    end else if (!stuck) begin
      if (l_out && !m_prev_l && m_idx > -3)      m_idx <= m_idx - 1;
      else if (r_out && !m_prev_r && m_idx < 3)  m_idx <= m_idx + 1;
    end
  end

  always_comb begin
    if (m_idx < 0)      pos = 3'(-m_idx);
    else if (m_idx > 0) pos = 3'(m_idx + 3);
    else                pos = 3'b000;
  end

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic set_pos(input int v);
    set_val = v;
    set_req = 1'b1;
    @(posedge clk);
    @(negedge clk);
    set_req = 1'b0;
  endtask

  // Starts a command at a negedge and tracks it to done/err.
  task automatic run_cmd(input string tag, input logic [2:0] tgt, input bit exp_ok,
                         input int exp_cyc, input int exp_l, input int exp_r,
                         input int exp_steps, input bit poke);
    int cyc, nl, nr, hi;
    bit fin, both;
    logic pl, pr;
    start  = 1'b1;
    target = tgt;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    cyc = 1; nl = 0; nr = 0; hi = 0; fin = 0; both = 0; pl = 0; pr = 0;
    while (!fin && cyc < 100) begin
      if (cyc == 1) check({tag, " busy@1"}, int'(busy), int'(tgt != 3'b111));
      if (l_out && !pl) nl++;
      if (r_out && !pr) nr++;
      if (l_out || r_out) hi++;
      if (l_out && r_out) both = 1;
      pl = l_out;
      pr = r_out;
      if (poke && cyc == 3) begin start = 1'b1; target = 3'b011; end
      if (poke && cyc == 4) start = 1'b0;
      if (done || err) begin
        fin = 1;
        check({tag, " done"}, int'(done), int'(exp_ok));
        check({tag, " err"}, int'(err), int'(!exp_ok));
        check({tag, " cycle"}, cyc, exp_cyc);
        check({tag, " busy_end"}, int'(busy), 0);
      end else begin
        @(negedge clk);
        cyc++;
      end
    end
    check({tag, " no_timeout"}, int'(fin), 1);
    check({tag, " l_pulses"}, nl, exp_l);
    check({tag, " r_pulses"}, nr, exp_r);
    check({tag, " high_cycles"}, hi, 2 * (exp_l + exp_r));
    check({tag, " exclusive"}, int'(both), 0);
    check({tag, " steps"}, int'(steps), exp_steps);
    @(negedge clk);
    check({tag, " after_busy"}, int'(busy), 0);
    check({tag, " after_pulse"}, int'(done | err), 0);
    check({tag, " after_lines"}, int'(l_out | r_out), 0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; target = 3'b000;
    stuck = 1'b0; set_req = 1'b1; set_val = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    set_req = 1'b0;
    check("reset l_out", int'(l_out), 0);
    check("reset r_out", int'(r_out), 0);
    check("reset busy", int'(busy), 0);
    check("reset done_err", int'(done | err), 0);
    check("reset steps", int'(steps), 0);
    reset = 1'b0;
    @(negedge clk);

    run_cmd("left3", 3'b011, 1, 17, 3, 0, 3, 0);
    check("left3 pos", int'(pos), 3);

    run_cmd("right6", 3'b110, 1, 32, 0, 6, 6, 0);
    check("right6 pos", int'(pos), 6);

    set_pos(2);
    run_cmd("at_target", 3'b101, 1, 2, 0, 0, 0, 0);
    run_cmd("invalid", 3'b111, 0, 1, 0, 0, 0, 0);

    set_pos(0);
    stuck = 1'b1;
    run_cmd("stuck", 3'b100, 0, 6, 0, 1, 1, 0);
    stuck = 1'b0;

    // Reset while the first left pulse is on the line.
    start = 1'b1; target = 3'b011;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("midpulse l_out", int'(l_out), 1);
    check("midpulse steps", int'(steps), 1);
    #2 reset = 1'b1;
    #1;
    check("async l_out", int'(l_out), 0);
    check("async busy", int'(busy), 0);
    check("async steps", int'(steps), 0);
    @(negedge clk);
    reset = 1'b0;
    set_pos(0);
    run_cmd("post_reset", 3'b000, 1, 2, 0, 0, 0, 0);

    run_cmd("restart_ignored", 3'b101, 1, 12, 0, 2, 2, 1);
    check("restart pos", int'(pos), 5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
